// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU results and load returns with pending-load scoreboard
module wb_arbiter #(
  parameter int WORD_WIDTH   = 16,
  parameter int IDX_WIDTH    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_alu_valid,
  input  logic [IDX_WIDTH-1:0]        in_alu_dst_idx,
  input  logic [WORD_WIDTH-1:0]       in_alu_result,
  output logic                        out_alu_stall,
  input  logic                        in_ld_issue,
  input  logic [IDX_WIDTH-1:0]        in_ld_issue_idx,
  input  logic                        in_ld_valid,
  input  logic [IDX_WIDTH-1:0]        in_ld_dst_idx,
  input  logic [WORD_WIDTH-1:0]       in_ld_data,
  output logic                        out_ld_ready,
  output logic                        out_write,
  output logic [IDX_WIDTH-1:0]        out_dst_idx,
  output logic [WORD_WIDTH-1:0]       out_dst,
  output logic [(1<<IDX_WIDTH)-1:0]   out_busy_mask
);

  localparam int NUM_REGS = 1 << IDX_WIDTH;
  localparam int CNT_W    = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]      r_starve_cnt;
  logic [NUM_REGS-1:0]   r_busy;
  logic                  r_write;
  logic [IDX_WIDTH-1:0]  r_dst_idx;
  logic [WORD_WIDTH-1:0] r_dst;

  logic                  w_starved;
  logic                  w_ld_acc;
  logic                  w_alu_acc;
  logic                  w_any_acc;
  logic [IDX_WIDTH-1:0]  w_sel_idx;
  logic [WORD_WIDTH-1:0] w_sel_data;
  logic [NUM_REGS-1:0]   w_set_mask;
  logic [NUM_REGS-1:0]   w_clr_mask;
  logic [NUM_REGS-1:0]   w_busy_next;

  // Once a load has been refused STARVE_LIMIT times in a row it wins over the ALU.
  assign w_starved     = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign out_ld_ready  = w_starved ? 1'b1 : ~in_alu_valid;
  assign out_alu_stall = w_starved & in_alu_valid & in_ld_valid;

  assign w_ld_acc   = in_ld_valid & out_ld_ready;
  assign w_alu_acc  = in_alu_valid & ~out_alu_stall;
  assign w_any_acc  = w_ld_acc | w_alu_acc;
  assign w_sel_idx  = w_ld_acc ? in_ld_dst_idx : in_alu_dst_idx;
  assign w_sel_data = w_ld_acc ? in_ld_data    : in_alu_result;

  // Scoreboard update: a new issue overrides a same-cycle return; register 0 is never tracked.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (in_ld_issue) w_set_mask = NUM_REGS'(1) << in_ld_issue_idx;
    if (w_ld_acc)    w_clr_mask = NUM_REGS'(1) << in_ld_dst_idx;
    w_busy_next    = ((r_busy & ~w_clr_mask) | w_set_mask) & ~NUM_REGS'(1);
  end

  // Starvation counter: counts consecutive refusals of a valid load, saturating at the limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_ld_acc || !in_ld_valid) begin
      r_starve_cnt <= '0;
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  // Registered write port; index/data hold when nothing is accepted, writes to r0 are suppressed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_write   <= 1'b0;
      r_dst_idx <= '0;
      r_dst     <= '0;
    end else begin
      r_write <= w_any_acc & (w_sel_idx != '0);
      if (w_any_acc) begin
        r_dst_idx <= w_sel_idx;
        r_dst     <= w_sel_data;
      end
    end
  end

  // Pending-load scoreboard register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_next;
  end

  assign out_write     = r_write;
  assign out_dst_idx   = r_dst_idx;
  assign out_dst       = r_dst;
  assign out_busy_mask = r_busy;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_alu_valid = 1'b0;
  logic [3:0]  in_alu_dst_idx = '0;
  logic [15:0] in_alu_result = '0;
  logic        out_alu_stall;
  logic        in_ld_issue = 1'b0;
  logic [3:0]  in_ld_issue_idx = '0;
  logic        in_ld_valid = 1'b0;
  logic [3:0]  in_ld_dst_idx = '0;
  logic [15:0] in_ld_data = '0;
  logic        out_ld_ready;
  logic        out_write;
  logic [3:0]  out_dst_idx;
  logic [15:0] out_dst;
  logic [15:0] out_busy_mask;

  int n_cmp = 0;
  int n_bad = 0;

  wb_arbiter #(.WORD_WIDTH(16), .IDX_WIDTH(4), .STARVE_LIMIT(3)) dut (
    .clock(clock), .reset(reset),
    .in_alu_valid(in_alu_valid), .in_alu_dst_idx(in_alu_dst_idx), .in_alu_result(in_alu_result),
    .out_alu_stall(out_alu_stall),
    .in_ld_issue(in_ld_issue), .in_ld_issue_idx(in_ld_issue_idx),
    .in_ld_valid(in_ld_valid), .in_ld_dst_idx(in_ld_dst_idx), .in_ld_data(in_ld_data),
    .out_ld_ready(out_ld_ready),
    .out_write(out_write), .out_dst_idx(out_dst_idx), .out_dst(out_dst),
    .out_busy_mask(out_busy_mask)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_alu_valid = 1'b0;
    in_ld_issue  = 1'b0;
    in_ld_valid  = 1'b0;
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_write", out_write, 0);
    chk("rst_idx", out_dst_idx, 0);
    chk("rst_dst", out_dst, 0);
    chk("rst_busy", out_busy_mask, 0);
    chk("rst_ld_ready", out_ld_ready, 1);
    chk("rst_stall", out_alu_stall, 0);
    #1 reset = 1'b0;
    tick();

    // ALU only
    in_alu_valid = 1'b1; in_alu_dst_idx = 4'd3; in_alu_result = 16'hBEEF;
    #1;
    chk("alu_stall", out_alu_stall, 0);
    chk("alu_ld_ready", out_ld_ready, 0);
    tick();
    idle_inputs();
    chk("alu_write", out_write, 1);
    chk("alu_idx", out_dst_idx, 3);
    chk("alu_dst", out_dst, 16'hBEEF);
    tick();
    chk("idle_write", out_write, 0);
    chk("idle_idx_hold", out_dst_idx, 3);
    chk("idle_dst_hold", out_dst, 16'hBEEF);

    // load lifecycle
    in_ld_issue = 1'b1; in_ld_issue_idx = 4'd5;
    tick();
    in_ld_issue = 1'b0;
    chk("ld_busy_set", out_busy_mask, 16'h0020);
    tick(); tick(); tick();
    in_ld_valid = 1'b1; in_ld_dst_idx = 4'd5; in_ld_data = 16'h1234;
    #1;
    chk("ld_ready", out_ld_ready, 1);
    tick();
    idle_inputs();
    chk("ld_write", out_write, 1);
    chk("ld_idx", out_dst_idx, 5);
    chk("ld_dst", out_dst, 16'h1234);
    chk("ld_busy_clr", out_busy_mask, 16'h0000);

    // register 0
    in_alu_valid = 1'b1; in_alu_dst_idx = 4'd0; in_alu_result = 16'hFFFF;
    tick();
    idle_inputs();
    chk("r0_alu_write", out_write, 0);
    in_ld_valid = 1'b1; in_ld_dst_idx = 4'd0; in_ld_data = 16'h5555;
    #1;
    chk("r0_ld_ready", out_ld_ready, 1);
    tick();
    idle_inputs();
    chk("r0_ld_write", out_write, 0);
    in_ld_issue = 1'b1; in_ld_issue_idx = 4'd0;
    tick();
    idle_inputs();
    chk("r0_busy", out_busy_mask, 16'h0000);

    // same-cycle set/clear on reg 7
    in_ld_issue = 1'b1; in_ld_issue_idx = 4'd7;
    tick();
    chk("sc_busy_set", out_busy_mask, 16'h0080);
    in_ld_valid = 1'b1; in_ld_dst_idx = 4'd7; in_ld_data = 16'h7777;
    tick();
    idle_inputs();
    chk("sc_write", out_write, 1);
    chk("sc_idx", out_dst_idx, 7);
    chk("sc_dst", out_dst, 16'h7777);
    chk("sc_busy_kept", out_busy_mask, 16'h0080);
    in_ld_valid = 1'b1; in_ld_dst_idx = 4'd7; in_ld_data = 16'h7778;
    tick();
    idle_inputs();
    chk("sc_busy_clr", out_busy_mask, 16'h0000);

    // contention and starvation
    in_ld_issue = 1'b1; in_ld_issue_idx = 4'd9;
    tick();
    in_ld_issue = 1'b0;
    in_ld_valid = 1'b1; in_ld_dst_idx = 4'd9; in_ld_data = 16'h9999;
    for (int c = 0; c < 3; c++) begin
      in_alu_valid = 1'b1; in_alu_dst_idx = 4'(c + 1); in_alu_result = 16'hA000 + 16'(c);
      #1;
      chk($sformatf("cont_ready_c%0d", c), out_ld_ready, 0);
      chk($sformatf("cont_stall_c%0d", c), out_alu_stall, 0);
      tick();
      chk($sformatf("cont_write_c%0d", c), out_write, 1);
      chk($sformatf("cont_idx_c%0d", c), out_dst_idx, c + 1);
      chk($sformatf("cont_dst_c%0d", c), out_dst, 32'hA000 + c);
    end
    in_alu_dst_idx = 4'd4; in_alu_result = 16'hA003;
    #1;
    chk("starve_ready", out_ld_ready, 1);
    chk("starve_stall", out_alu_stall, 1);
    tick();
    in_ld_valid = 1'b0;
    chk("starve_ld_write", out_write, 1);
    chk("starve_ld_idx", out_dst_idx, 9);
    chk("starve_ld_dst", out_dst, 16'h9999);
    chk("starve_busy", out_busy_mask, 16'h0000);
    #1;
    chk("resume_stall", out_alu_stall, 0);
    tick();
    in_alu_valid = 1'b0;
    chk("resume_write", out_write, 1);
    chk("resume_idx", out_dst_idx, 4);
    chk("resume_dst", out_dst, 16'hA003);

    // reset mid-stream with counter saturated
    in_ld_issue = 1'b1; in_ld_issue_idx = 4'd2;
    tick();
    in_ld_issue_idx = 4'd5;
    tick();
    in_ld_issue = 1'b0;
    in_ld_valid = 1'b1; in_ld_dst_idx = 4'd2; in_ld_data = 16'h2222;
    in_alu_valid = 1'b1; in_alu_dst_idx = 4'd6; in_alu_result = 16'h6666;
    tick(); tick(); tick();
    chk("mid_busy", out_busy_mask, 16'h0024);
    chk("mid_write", out_write, 1);
    #1;
    chk("mid_starved", out_ld_ready, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_write", out_write, 0);
    chk("mid_rst_idx", out_dst_idx, 0);
    chk("mid_rst_dst", out_dst, 0);
    chk("mid_rst_busy", out_busy_mask, 0);
    chk("mid_rst_ready", out_ld_ready, 0);
    chk("mid_rst_stall", out_alu_stall, 0);
    #1 reset = 1'b0;
    idle_inputs();
    tick();
    chk("post_rst_write", out_write, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
